// File: rtl/pwm_cmp_regbank.sv
// Register bank between the I2C slave byte-write interface and the PWM core.
// Stages an 18-bit compare target in three bytes and commits it atomically at a PWM period boundary.
module pwm_cmp_regbank #(
  parameter logic [17:0] RESET_CMPA = 18'h00000,
  parameter int          ADDR_W     = 8
) (
  input  logic              clk_USB,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  input  logic              period_start,
  output logic [17:0]       cmpa_active,
  output logic              cmpa_update,
  output logic              commit_pending
);

  localparam logic [ADDR_W-1:0] A_STG0   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STG1   = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_STG2   = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_ACT0   = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] A_ACT1   = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_ACT2   = ADDR_W'(8'h07);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t      state_q, state_d;
  logic [17:0] stage_q, stage_d;
  logic [17:0] active_q, active_d;
  logic        dirty_q, dirty_d;
  logic        update_q, update_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic commit_wr, force_commit, arm_commit, apply_commit, stage_wr;
  logic [7:0] rd_mux;

  // Decode of the commit control register and the staging bytes.
  assign commit_wr    = wr_en && (addr == A_COMMIT);
  assign force_commit = commit_wr && wr_data[0];
  assign arm_commit   = commit_wr && !wr_data[0];
  assign apply_commit = force_commit || ((state_q == ARMED) && period_start);
  assign stage_wr     = wr_en && ((addr == A_STG0) || (addr == A_STG1) || (addr == A_STG2));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rd_mux = 8'h00;
    case (addr)
      A_STG0:   rd_mux = stage_q[7:0];
      A_STG1:   rd_mux = stage_q[15:8];
      A_STG2:   rd_mux = {6'b0, stage_q[17:16]};
      A_STATUS: rd_mux = {6'b0, dirty_q, (state_q == ARMED)};
      A_ACT0:   rd_mux = active_q[7:0];
      A_ACT1:   rd_mux = active_q[15:8];
      A_ACT2:   rd_mux = {6'b0, active_q[17:16]};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    active_d  = active_q;
    dirty_d   = dirty_q;
    update_d  = apply_commit;
    rd_data_d = rd_en ? rd_mux : rd_data_q;

    // The commit takes the pre-write stage; a coincident byte write lands afterwards.
    if (apply_commit) begin
      active_d = stage_q;
      dirty_d  = 1'b0;
    end

    if (wr_en) begin
      case (addr)
        A_STG0:  stage_d[7:0]   = wr_data;
        A_STG1:  stage_d[15:8]  = wr_data;
        A_STG2:  stage_d[17:16] = wr_data[1:0];
        default: ;
      endcase
    end
    if (stage_wr) dirty_d = 1'b1;

    // An arm in the same cycle as a boundary is not consumed by that boundary.
    if (force_commit)      state_d = IDLE;
    else if (arm_commit)   state_d = ARMED;
    else if (apply_commit) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_USB) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stage_q   <= RESET_CMPA;
      active_q  <= RESET_CMPA;
      dirty_q   <= 1'b0;
      update_q  <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
      dirty_q   <= dirty_d;
      update_q  <= update_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign cmpa_active    = active_q;
  assign cmpa_update    = update_q;
  assign commit_pending = (state_q == ARMED);

endmodule

// File: tb/tb_pwm_cmp_regbank.sv
// Self-checking bench for pwm_cmp_regbank: directed vector table followed by
// randomized traffic compared against a behavioural register-bank model.
module tb_pwm_cmp_regbank;

  logic        clk_USB = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [7:0]  addr    = 8'h00;
  logic [7:0]  wr_data = 8'h00;
  logic        period_start = 1'b0;
  logic [7:0]  rd_data;
  logic [17:0] cmpa_active;
  logic        cmpa_update;
  logic        commit_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_USB = ~clk_USB;

  pwm_cmp_regbank #(.RESET_CMPA(18'h00000), .ADDR_W(8)) dut (
    .clk_USB        (clk_USB),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .addr           (addr),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .period_start   (period_start),
    .cmpa_active    (cmpa_active),
    .cmpa_update    (cmpa_update),
    .commit_pending (commit_pending)
  );

  typedef struct {
    bit         rst;    // drive rst_n low this cycle
    bit         we;
    bit         re;
    logic [7:0] a;
    logic [7:0] d;
    bit         ps;
    logic [17:0] exp_act;
    bit         exp_upd;
    bit         exp_pend;
    bit         chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic drive(input bit rst, input bit we, input bit re, input logic [7:0] a,
                       input logic [7:0] d, input bit ps);
    rst_n        = ~rst;
    wr_en        = we;
    rd_en        = re;
    addr         = a;
    wr_data      = d;
    period_start = ps;
    @(posedge clk_USB);
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit we, bit re, logic [7:0] a, logic [7:0] d, bit ps,
                              logic [17:0] act, bit upd, bit pend, bit chk_rd, logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.a = a; v.d = d; v.ps = ps;
    v.exp_act = act; v.exp_upd = upd; v.exp_pend = pend; v.chk_rd = chk_rd; v.exp_rd = rd;
    return v;
  endfunction

  // Behavioural model state.
  logic [17:0] m_stage, m_active;
  bit          m_armed, m_dirty, m_upd;
  logic [7:0]  m_rd;

  function automatic logic [7:0] m_read(logic [7:0] a);
    case (a)
      8'h00: return m_stage[7:0];
      8'h01: return m_stage[15:8];
      8'h02: return {6'b0, m_stage[17:16]};
      8'h04: return {6'b0, m_dirty, m_armed};
      8'h05: return m_active[7:0];
      8'h06: return m_active[15:8];
      8'h07: return {6'b0, m_active[17:16]};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit we, input bit re, input logic [7:0] a,
                            input logic [7:0] d, input bit ps);
    logic [7:0] rv;
    bit forced, armreq, applied;
    rv = m_read(a);
    if (rst) begin
      m_stage = 18'h0; m_active = 18'h0; m_armed = 0; m_dirty = 0; m_upd = 0; m_rd = 8'h00;
      return;
    end
    forced  = we && (a == 8'h03) && d[0];
    armreq  = we && (a == 8'h03) && !d[0];
    applied = forced || (m_armed && ps);
    m_upd   = applied;
    if (applied) begin
      m_active = m_stage;
      m_dirty  = 0;
    end
    if (we && a <= 8'h02) begin
      m_dirty = 1;
      if (a == 8'h00) m_stage[7:0] = d;
      else if (a == 8'h01) m_stage[15:8] = d;
      else m_stage[17:16] = d[1:0];
    end
    // A force leaves nothing pending; a fresh arm request always leaves one pending.
    if (forced) m_armed = 0;
    else if (armreq) m_armed = 1;
    else if (applied) m_armed = 0;
    if (re) m_rd = rv;
  endtask

  initial begin
    // Directed sequence: reset, synchronized commit, force, coincident events, reset mid-arm.
    tbl.push_back(mk(1,0,0,8'h00,8'h00,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,0,1,8'h04,8'h00,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,1,0,8'h00,8'h44,0, 18'h00000,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h01,8'h13,0, 18'h00000,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h02,8'h00,0, 18'h00000,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h03,8'h00,0, 18'h00000,0,1, 0,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0, 18'h00000,0,1, 0,8'h00));
    tbl.push_back(mk(0,0,1,8'h04,8'h00,0, 18'h00000,0,1, 1,8'h03));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,1, 18'h01344,1,0, 1,8'h03));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0, 18'h01344,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,1,8'h04,8'h00,0, 18'h01344,0,0, 1,8'h00));
    tbl.push_back(mk(0,1,0,8'h00,8'hCD,0, 18'h01344,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h01,8'hAB,0, 18'h01344,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h02,8'hFE,0, 18'h01344,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h03,8'h01,1, 18'h2ABCD,1,0, 0,8'h00));
    tbl.push_back(mk(0,0,1,8'h02,8'h00,0, 18'h2ABCD,0,0, 1,8'h02));
    tbl.push_back(mk(0,0,1,8'h07,8'h00,0, 18'h2ABCD,0,0, 1,8'h02));
    tbl.push_back(mk(0,0,1,8'h05,8'h00,0, 18'h2ABCD,0,0, 1,8'hCD));
    tbl.push_back(mk(0,1,0,8'h00,8'h11,0, 18'h2ABCD,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h03,8'h00,1, 18'h2ABCD,0,1, 0,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0, 18'h2ABCD,0,1, 0,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,1, 18'h2AB11,1,0, 0,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0, 18'h2AB11,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h00,8'h44,0, 18'h2AB11,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h01,8'h13,0, 18'h2AB11,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h02,8'h00,0, 18'h2AB11,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h03,8'h00,0, 18'h2AB11,0,1, 0,8'h00));
    tbl.push_back(mk(0,1,0,8'h00,8'h55,1, 18'h01344,1,0, 0,8'h00));
    tbl.push_back(mk(0,0,1,8'h04,8'h00,0, 18'h01344,0,0, 1,8'h02));
    tbl.push_back(mk(0,0,1,8'h00,8'h00,0, 18'h01344,0,0, 1,8'h55));
    tbl.push_back(mk(0,1,0,8'h03,8'h00,0, 18'h01344,0,1, 0,8'h00));
    tbl.push_back(mk(1,0,0,8'h00,8'h00,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,1, 18'h00000,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,1,8'h1F,8'h00,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,0,1,8'h04,8'h00,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,1,1,8'h01,8'h77,0, 18'h00000,0,0, 1,8'h00));
    tbl.push_back(mk(0,0,1,8'h01,8'h00,0, 18'h00000,0,0, 1,8'h77));
    tbl.push_back(mk(0,1,1,8'h03,8'h00,0, 18'h00000,0,1, 1,8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d, tbl[i].ps);
      check($sformatf("vec%0d cmpa_active", i), 32'(cmpa_active), 32'(tbl[i].exp_act));
      check($sformatf("vec%0d cmpa_update", i), 32'(cmpa_update), 32'(tbl[i].exp_upd));
      check($sformatf("vec%0d commit_pending", i), 32'(commit_pending), 32'(tbl[i].exp_pend));
      if (tbl[i].chk_rd)
        check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].exp_rd));
    end

    // Randomized traffic against the model; start both from reset.
    model_step(1, 0, 0, 8'h00, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 8'h00, 0);
    for (int c = 0; c < 4000; c++) begin
      bit rst, we, re, ps;
      logic [7:0] a, d;
      int sel;
      rst = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 2) == 0);
      ps  = ($urandom_range(0, 4) == 0);
      sel = int'($urandom_range(0, 11));
      if (sel <= 7) a = 8'(sel);
      else if (sel == 8) a = 8'h03;
      else if (sel == 9) a = 8'h1F;
      else if (sel == 10) a = 8'h08;
      else a = 8'hFF;
      d = 8'($urandom);
      model_step(rst, we, re, a, d, ps);
      drive(rst, we, re, a, d, ps);
      check($sformatf("rnd%0d cmpa_active", c), 32'(cmpa_active), 32'(m_active));
      check($sformatf("rnd%0d cmpa_update", c), 32'(cmpa_update), 32'(m_upd));
      check($sformatf("rnd%0d commit_pending", c), 32'(commit_pending), 32'(m_armed));
      check($sformatf("rnd%0d rd_data", c), 32'(rd_data), 32'(m_rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
